cola_dispense_arbiter: RTL and testbench

//  Shares one cola dispenser between two coin channels (A, B). Each channel accumulates coins.
//  A channel requests the dispenser once its credit reaches PRICE.
//  A round-robin FSM grants the dispenser, deducts PRICE and holds it busy for DISP_CYCLES.
//  It then emits a one-cycle cola pulse to the owning channel.

---
 rtl/cola_dispense_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cola_dispense_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cola_dispense_arbiter.sv
// Round-robin arbiter sharing one cola dispenser between two coin channels.
// Each channel accumulates credit; the first with enough credit is granted and served.
module cola_dispense_arbiter #(
  parameter int PRICE       = 3,
  parameter int DISP_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pi_money_a,
  input  logic             pi_money_b,
  output logic             po_cola_a,
  output logic             po_cola_b,
  output logic             po_reject_a,
  output logic             po_reject_b,
  output logic             po_busy,
  output logic             po_owner,
  output logic [CNT_W-1:0] po_credit_a,
  output logic [CNT_W-1:0] po_credit_b
);

  localparam int CW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PRICE_C    = CNT_W'(PRICE);
  localparam logic [CNT_W-1:0] CMAX_C     = CNT_W'(2 * PRICE - 1);
  localparam logic [CW-1:0]    CNT_LOAD_C = CW'(DISP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             ptr_r;
  logic             owner_r;
  logic             busy_r;
  logic             cola_a_r;
  logic             cola_b_r;
  logic             reject_a_r;
  logic             reject_b_r;
  logic [CNT_W-1:0] credit_a_r;
  logic [CNT_W-1:0] credit_b_r;

  logic             req_a_s;
  logic             req_b_s;
  logic             grant_s;
  logic             sel_s;
  logic             deduct_a_s;
  logic             deduct_b_s;
  logic [CNT_W:0]   next_a_s;
  logic [CNT_W:0]   next_b_s;

  // Returns {reject, next_credit}; a deduct always leaves room for a same-edge coin.
  function automatic logic [CNT_W:0] credit_next(input logic [CNT_W-1:0] credit,
                                                 input logic coin,
                                                 input logic deduct);
    logic [CNT_W:0] res;
    if (deduct) begin
      res = {1'b0, credit - PRICE_C + CNT_W'(coin)};
    end else if (coin && (credit == CMAX_C)) begin
      res = {1'b1, credit};
    end else if (coin) begin
      res = {1'b0, credit + CNT_W'(1)};
    end else begin
      res = {1'b0, credit};
    end
    return res;
  endfunction

  assign req_a_s = (credit_a_r >= PRICE_C);
  assign req_b_s = (credit_b_r >= PRICE_C);

  // Grant selection: only while idle, pointer breaks ties.
  always_comb begin
    grant_s = 1'b0;
    sel_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req_a_s && req_b_s) begin
        grant_s = 1'b1;
        sel_s   = ptr_r;
      end else if (req_a_s) begin
        grant_s = 1'b1;
        sel_s   = 1'b0;
      end else if (req_b_s) begin
        grant_s = 1'b1;
        sel_s   = 1'b1;
      end else begin
        grant_s = 1'b0;
        sel_s   = 1'b0;
      end
    end else begin
      grant_s = 1'b0;
      sel_s   = 1'b0;
    end
  end

  assign deduct_a_s = grant_s & ~sel_s;
  assign deduct_b_s = grant_s & sel_s;
  assign next_a_s   = credit_next(credit_a_r, pi_money_a, deduct_a_s);
  assign next_b_s   = credit_next(credit_b_r, pi_money_b, deduct_b_s);

  // Credit accumulation, deduction on grant and saturation reject pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      credit_a_r <= {CNT_W{1'b0}};
      credit_b_r <= {CNT_W{1'b0}};
      reject_a_r <= 1'b0;
      reject_b_r <= 1'b0;
    end else begin
      credit_a_r <= next_a_s[CNT_W-1:0];
      credit_b_r <= next_b_s[CNT_W-1:0];
      reject_a_r <= next_a_s[CNT_W];
      reject_b_r <= next_b_s[CNT_W];
    end
  end

  // Dispense FSM with registered busy/owner/cola outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CW{1'b0}};
      ptr_r    <= 1'b0;
      owner_r  <= 1'b0;
      busy_r   <= 1'b0;
      cola_a_r <= 1'b0;
      cola_b_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cola_a_r <= 1'b0;
          cola_b_r <= 1'b0;
          if (grant_s) begin
            state_r <= ST_DISPENSE;
            owner_r <= sel_s;
            busy_r  <= 1'b1;
            cnt_r   <= CNT_LOAD_C;
            ptr_r   <= ~sel_s;
          end
        end
        ST_DISPENSE: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r  <= ST_DONE;
            cola_a_r <= ~owner_r;
            cola_b_r <= owner_r;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_DONE: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          cola_a_r <= 1'b0;
          cola_b_r <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          cola_a_r <= 1'b0;
          cola_b_r <= 1'b0;
        end
      endcase
    end
  end

  assign po_cola_a   = cola_a_r;
  assign po_cola_b   = cola_b_r;
  assign po_reject_a = reject_a_r;
  assign po_reject_b = reject_b_r;
  assign po_busy     = busy_r;
  assign po_owner    = owner_r;
  assign po_credit_a = credit_a_r;
  assign po_credit_b = credit_b_r;

endmodule

// File: tb/tb_cola_dispense_arbiter.sv
// Randomized bench for cola_dispense_arbiter against a cycle-level transaction model.
module tb_cola_dispense_arbiter;

  localparam int PRICE = 3;
  localparam int DISP  = 4;
  localparam int CNT_W = 3;
  localparam int CMAX  = 2 * PRICE - 1;

  logic             sys_clk;
  logic             sys_rst_n;
  logic             pi_money_a;
  logic             pi_money_b;
  logic             po_cola_a;
  logic             po_cola_b;
  logic             po_reject_a;
  logic             po_reject_b;
  logic             po_busy;
  logic             po_owner;
  logic [CNT_W-1:0] po_credit_a;
  logic [CNT_W-1:0] po_credit_b;

  int n_checks;
  int n_errors;

  int m_credit [2];
  int m_cola   [2];
  int m_rej    [2];
  int m_busy;
  int m_owner;
  int m_ptr;
  int m_grant;
  int m_edge;

  cola_dispense_arbiter #(.PRICE(PRICE), .DISP_CYCLES(DISP), .CNT_W(CNT_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pi_money_a  (pi_money_a),
    .pi_money_b  (pi_money_b),
    .po_cola_a   (po_cola_a),
    .po_cola_b   (po_cola_b),
    .po_reject_a (po_reject_a),
    .po_reject_b (po_reject_b),
    .po_busy     (po_busy),
    .po_owner    (po_owner),
    .po_credit_a (po_credit_a),
    .po_credit_b (po_credit_b)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit[0] = 0; m_credit[1] = 0;
    m_cola[0] = 0;   m_cola[1] = 0;
    m_rej[0] = 0;    m_rej[1] = 0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_grant = 0; m_edge = 0;
  endtask

  // One clock edge of the vending rules: grant when free, then coins, then dispense timing.
  task automatic model_edge(input int ca, input int cb);
    int coin [2];
    int req  [2];
    int grant;
    int sel;
    coin[0] = ca; coin[1] = cb;
    m_edge++;
    for (int i = 0; i < 2; i++) req[i] = (m_credit[i] >= PRICE) ? 1 : 0;
    grant = 0;
    sel = 0;
    if (m_busy == 0 && (req[0] + req[1]) > 0) begin
      grant = 1;
      sel = (req[0] == 1 && req[1] == 1) ? m_ptr : ((req[0] == 1) ? 0 : 1);
      m_ptr = 1 - sel;
      m_owner = sel;
      m_busy = 1;
      m_grant = m_edge;
    end
    for (int i = 0; i < 2; i++) begin
      m_rej[i] = 0;
      if (grant == 1 && sel == i) m_credit[i] = m_credit[i] - PRICE + coin[i];
      else if (coin[i] == 1 && m_credit[i] == CMAX) m_rej[i] = 1;
      else m_credit[i] = m_credit[i] + coin[i];
    end
    m_cola[0] = 0; m_cola[1] = 0;
    if (grant == 0 && m_busy == 1) begin
      if (m_edge == m_grant + DISP) m_cola[m_owner] = 1;
      else if (m_edge == m_grant + DISP + 1) m_busy = 0;
    end
  endtask

  task automatic check_all();
    check_eq("cola_a",   po_cola_a,   m_cola[0]);
    check_eq("cola_b",   po_cola_b,   m_cola[1]);
    check_eq("reject_a", po_reject_a, m_rej[0]);
    check_eq("reject_b", po_reject_b, m_rej[1]);
    check_eq("busy",     po_busy,     m_busy);
    check_eq("owner",    po_owner,    m_owner);
    check_eq("credit_a", po_credit_a, m_credit[0]);
    check_eq("credit_b", po_credit_b, m_credit[1]);
  endtask

  // Called at a falling edge: drive coins, take the rising edge, compare.
  task automatic cycle(input logic ca, input logic cb);
    pi_money_a = ca;
    pi_money_b = cb;
    @(posedge sys_clk);
    model_edge(int'(ca), int'(cb));
    #1;
    check_all();
    @(negedge sys_clk);
  endtask

  // Asynchronous reset pulse placed between edges, released on a falling edge.
  task automatic async_reset();
    #2;
    sys_rst_n = 1'b0;
    pi_money_a = 1'b0;
    pi_money_b = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge sys_clk);
    @(negedge sys_clk);
    check_all();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    sys_rst_n  = 1'b0;
    pi_money_a = 1'b0;
    pi_money_b = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_all();
    sys_rst_n = 1'b1;

    // Idle with no coins, then an async reset mid-run.
    repeat (20) cycle(1'b0, 1'b0);
    async_reset();

    // Single A purchase.
    repeat (3) cycle(1'b1, 1'b0);
    check_eq("t2_credit_a", po_credit_a, 3);
    repeat (10) cycle(1'b0, 1'b0);

    // Simultaneous requests twice, order alternates.
    repeat (2) begin
      repeat (3) cycle(1'b1, 1'b1);
      repeat (16) cycle(1'b0, 1'b0);
    end

    // B dispensing while A saturates.
    repeat (3) cycle(1'b0, 1'b1);
    repeat (7) cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);

    // Coin on A's own grant edge.
    async_reset();
    repeat (4) cycle(1'b1, 1'b0);
    check_eq("t5_credit_a", po_credit_a, 1);
    check_eq("t5_reject_a", po_reject_a, 0);
    repeat (10) cycle(1'b0, 1'b0);

    // Reset mid-dispense, then the dispenser must be free for B.
    repeat (3) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    async_reset();
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check_eq("t6_busy", po_busy, 1);
    check_eq("t6_owner", po_owner, 1);
    repeat (10) cycle(1'b0, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      cycle(($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
